// File: rtl/clk_switch_ctrl.sv
// ---------------------------------------------------------------------------
// clk_switch_ctrl
//   Arbitrates and sequences source-switch requests for a 2:1 glitch-free
//   clock mux. Requesters are granted one at a time in round-robin order.
//   A granted switch drives the mux select, holds it for a settle window,
//   acknowledges the requester, and then blocks further grants for a dwell
//   window. A request whose target already matches the current select is
//   acknowledged without touching sel and without a dwell window.
//   The block runs on an always-on reference clock, never on a muxed clock.
//
// Parameters
//   NUM_REQ     number of requesters (>=2)
//   SETTLE_CYC  cycles sel is held after a change before ack (>=1)
//   DWELL_CYC   cycles after a completed switch with no new grant (>=0)
//
// Ports
//   clk         reference clock, free-running
//   rst         asynchronous active-high reset
//   req         level request per requester, held until its ack
//   req_src     per-requester target source: 0=clk1, 1=clk2
//   ack         one-cycle one-hot pulse to the granted requester
//   sel         registered select to the clock mux
//   busy        high whenever the controller is not idle
//   last_grant  index of the most recently acknowledged requester
// ---------------------------------------------------------------------------
module clk_switch_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int SETTLE_CYC = 8,
  parameter int DWELL_CYC  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_src,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       sel,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] last_grant
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  // With no dwell window the load value is never used; keep it at zero so it
  // never goes negative.
  localparam logic [CNT_W-1:0] DWELL_LOAD  = (DWELL_CYC > 0) ? CNT_W'(DWELL_CYC - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACK,
    DWELL
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] win, win_n;
  logic [IDX_W-1:0] last_n;
  logic [IDX_W-1:0] pick;
  logic             found;
  logic             switched, switched_n;
  logic             sel_n;

  // Round-robin search: scan from the pointer upwards, wrapping, and take the
  // first active request.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[IDX_W'((int'(ptr) + i) % NUM_REQ)]) begin
        found = 1'b1;
        pick  = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  // Next-state logic. sel only ever changes on the IDLE->SETTLE transition;
  // the target is sampled once at grant so later req_src changes are ignored.
  // last_grant is updated on the edge that enters ACK so it already names the
  // winner while the ack pulse is visible.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ptr_n      = ptr;
    win_n      = win;
    switched_n = switched;
    sel_n      = sel;
    last_n     = last_grant;
    case (state)
      IDLE: begin
        if (found) begin
          win_n = pick;
          ptr_n = (pick == LAST_IDX) ? '0 : pick + 1'b1;
          if (req_src[pick] != sel) begin
            sel_n      = req_src[pick];
            cnt_n      = SETTLE_LOAD;
            switched_n = 1'b1;
            state_n    = SETTLE;
          end else begin
            switched_n = 1'b0;
            last_n     = pick;
            state_n    = ACK;
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          last_n  = win;
          state_n = ACK;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ACK: begin
        if (switched && (DWELL_CYC > 0)) begin
          cnt_n   = DWELL_LOAD;
          state_n = DWELL;
        end else begin
          state_n = IDLE;
        end
      end
      DWELL: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register. Reset drops sel straight back to clk1 and forgets any
  // grant in flight; the mux itself copes with that abrupt switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      win        <= '0;
      switched   <= 1'b0;
      sel        <= 1'b0;
      last_grant <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ptr        <= ptr_n;
      win        <= win_n;
      switched   <= switched_n;
      sel        <= sel_n;
      last_grant <= last_n;
    end
  end

  // Outputs decoded from registered state only, so ack is one-hot or zero.
  always_comb begin
    ack = '0;
    if (state == ACK) begin
      ack[win] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_switch_ctrl
//   Directed bench for clk_switch_ctrl with NUM_REQ=4, SETTLE_CYC=8,
//   DWELL_CYC=16. Inputs change 1 ns after a rising edge and outputs are
//   observed at that same point. "Cycle k" below means the observation 1 ns
//   after the k-th edge following the edge that sampled the request.
//   Expected timing for a switch: sel=1 and busy=1 at cycle 0, ack at
//   cycle 8, DWELL occupies cycles 9..24, busy low again at cycle 25.
// ---------------------------------------------------------------------------
module tb_clk_switch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] req_src = 4'b0000;
  logic [3:0] ack;
  logic       sel;
  logic       busy;
  logic [1:0] last_grant;

  int vectors = 0;
  int miscompares = 0;

  clk_switch_ctrl #(
    .NUM_REQ   (4),
    .SETTLE_CYC(8),
    .DWELL_CYC (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_src   (req_src),
    .ack       (ack),
    .sel       (sel),
    .busy      (busy),
    .last_grant(last_grant)
  );

  // 10 ns reference clock, rising edges at 5, 15, 25 ns ...
  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset pulse over one rising edge, released 1 ns after that edge.
  task automatic do_reset;
    rst     = 1'b1;
    req     = 4'b0000;
    req_src = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reset values, then an idle stretch where nothing may move.
  task automatic test_reset;
    rst = 1'b1;
    #6;
    rst = 1'b0;
    vectors++;
    if (sel !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000 || last_grant !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got sel=%b busy=%b ack=%b last_grant=%0d expected sel=0 busy=0 ack=0000 last_grant=0",
               sel, busy, ack, last_grant);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (sel !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL reset_idle cycle %0d: got sel=%b busy=%b ack=%b expected sel=0 busy=0 ack=0000",
                 k, sel, busy, ack);
      end
    end
  endtask

  // Requester 1 asks for clk2 from sel=0.
  task automatic test_single_switch;
    logic [3:0] exp_ack;
    logic       exp_busy;
    req     = 4'b0010;
    req_src = 4'b0010;
    tick();
    vectors++;
    if (sel !== 1'b1 || busy !== 1'b1 || ack !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL switch_grant: got sel=%b busy=%b ack=%b expected sel=1 busy=1 ack=0000",
               sel, busy, ack);
    end
    for (int k = 1; k <= 25; k++) begin
      tick();
      exp_ack  = (k == 8) ? 4'b0010 : 4'b0000;
      exp_busy = (k <= 24);
      vectors++;
      if (ack !== exp_ack || busy !== exp_busy || sel !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL switch_seq cycle %0d: got ack=%b busy=%b sel=%b expected ack=%b busy=%b sel=1",
                 k, ack, busy, sel, exp_ack, exp_busy);
      end
      if (k == 8) begin
        vectors++;
        if (last_grant !== 2'd1) begin
          miscompares++;
          $display("[TB] FAIL switch_last_grant: got %0d expected 1", last_grant);
        end
        req = 4'b0000;
      end
    end
  endtask

  // Requester 2 asks for clk2 while sel is already 1: immediate ack, no dwell.
  task automatic test_noop;
    req     = 4'b0100;
    req_src = 4'b0100;
    tick();
    vectors++;
    if (ack !== 4'b0100 || sel !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL noop_ack: got ack=%b sel=%b busy=%b expected ack=0100 sel=1 busy=1",
               ack, sel, busy);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (ack !== 4'b0000 || sel !== 1'b1 || busy !== 1'b0 || last_grant !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL noop_after: got ack=%b sel=%b busy=%b last_grant=%0d expected ack=0000 sel=1 busy=0 last_grant=2",
               ack, sel, busy, last_grant);
    end
  endtask

  // All four requesters at once with targets 0,1,0,1 from sel=0, pointer 0.
  // Expected: grants 0 (no-op), 1, 2, 3 in that order; three sel changes,
  // each at least SETTLE+1+DWELL = 25 cycles after the previous one.
  task automatic test_round_robin;
    logic [3:0] exp_ack;
    logic       prev_sel;
    int         n_grant;
    int         n_change;
    int         change_cyc[4];
    do_reset();
    req      = 4'b1111;
    req_src  = 4'b1010;
    prev_sel = 1'b0;
    n_grant  = 0;
    n_change = 0;
    for (int c = 0; c < 4; c++) change_cyc[c] = 0;
    for (int cyc = 1; cyc <= 200 && n_grant < 4; cyc++) begin
      tick();
      if (sel !== prev_sel) begin
        if (n_change < 4) change_cyc[n_change] = cyc;
        n_change++;
        prev_sel = sel;
      end
      vectors++;
      if ($countones(ack) > 1) begin
        miscompares++;
        $display("[TB] FAIL rr_onehot cycle %0d: got ack=%b expected at most one bit set", cyc, ack);
      end
      if (ack !== 4'b0000) begin
        exp_ack = 4'b0001 << n_grant;
        vectors++;
        if (ack !== exp_ack) begin
          miscompares++;
          $display("[TB] FAIL rr_order grant %0d: got ack=%b expected ack=%b", n_grant, ack, exp_ack);
        end
        req = req & ~ack;
        n_grant++;
      end
    end
    vectors++;
    if (n_grant != 4) begin
      miscompares++;
      $display("[TB] FAIL rr_timeout: got %0d grants expected 4", n_grant);
    end
    vectors++;
    if (n_change != 3) begin
      miscompares++;
      $display("[TB] FAIL rr_sel_changes: got %0d expected 3", n_change);
    end else begin
      vectors++;
      if (change_cyc[1] - change_cyc[0] < 25 || change_cyc[2] - change_cyc[1] < 25) begin
        miscompares++;
        $display("[TB] FAIL rr_spacing: got gaps %0d and %0d expected both >= 25",
                 change_cyc[1] - change_cyc[0], change_cyc[2] - change_cyc[1]);
      end
    end
    vectors++;
    if (sel !== 1'b1 || last_grant !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL rr_final: got sel=%b last_grant=%0d expected sel=1 last_grant=3", sel, last_grant);
    end
  endtask

  // Requester 3 drops req (and scrambles req_src) 3 cycles into SETTLE;
  // the switch must still complete and ack must still fire at cycle 8.
  task automatic test_dropped;
    logic [3:0] exp_ack;
    logic       exp_busy;
    do_reset();
    req     = 4'b1000;
    req_src = 4'b1000;
    tick();
    vectors++;
    if (sel !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL drop_grant: got sel=%b busy=%b expected sel=1 busy=1", sel, busy);
    end
    for (int k = 1; k <= 25; k++) begin
      tick();
      exp_ack  = (k == 8) ? 4'b1000 : 4'b0000;
      exp_busy = (k <= 24);
      vectors++;
      if (ack !== exp_ack || busy !== exp_busy || sel !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL drop_seq cycle %0d: got ack=%b busy=%b sel=%b expected ack=%b busy=%b sel=1",
                 k, ack, busy, sel, exp_ack, exp_busy);
      end
      if (k == 3) begin
        req     = 4'b0000;
        req_src = 4'b0000;
      end
    end
    vectors++;
    if (last_grant !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL drop_last_grant: got %0d expected 3", last_grant);
    end
  endtask

  // Reset 4 cycles into a switch: everything returns to reset values at once
  // and no ack appears. Afterwards requests 2 and 3 are pending; with the
  // pointer back at 0 requester 2 must win (a stale pointer of 3 would pick 3).
  task automatic test_reset_mid_settle;
    logic [3:0] exp_ack;
    do_reset();
    req     = 4'b0100;
    req_src = 4'b0100;
    tick();
    vectors++;
    if (sel !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_grant: got sel=%b expected sel=1", sel);
    end
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (sel !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000 || last_grant !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_abort: got sel=%b busy=%b ack=%b last_grant=%0d expected sel=0 busy=0 ack=0000 last_grant=0",
               sel, busy, ack, last_grant);
    end
    req     = 4'b1100;
    req_src = 4'b1100;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (sel !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL rstmid_hold cycle %0d: got sel=%b busy=%b ack=%b expected sel=0 busy=0 ack=0000",
                 k, sel, busy, ack);
      end
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (sel !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_regrant: got sel=%b busy=%b expected sel=1 busy=1", sel, busy);
    end
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_ack = (k == 8) ? 4'b0100 : 4'b0000;
      vectors++;
      if (ack !== exp_ack) begin
        miscompares++;
        $display("[TB] FAIL rstmid_ack cycle %0d: got ack=%b expected ack=%b", k, ack, exp_ack);
      end
      if (k == 8) req = 4'b1000;
    end
    vectors++;
    if (last_grant !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL rstmid_last_grant: got %0d expected 2", last_grant);
    end
  endtask

  initial begin
    test_reset();
    test_single_switch();
    test_noop();
    test_round_robin();
    test_dropped();
    test_reset_mid_settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
